// File: rtl/cam_lvds_align_pkg.sv
// State encodings and defaults for the LVDS bitslip training controller.
// Shared by the top level and the per-lane word aligner.
package cam_lvds_align_pkg;

   typedef enum logic [1:0] {
      T_IDLE,
      T_WAIT_LOCK,
      T_TRAIN,
      T_DONE
   } top_state_t;

   typedef enum logic [2:0] {
      L_IDLE,
      L_CHECK,
      L_SLIP,
      L_SETTLE,
      L_DONE,
      L_FAILED
   } lane_state_t;

   localparam logic [7:0] DEF_TRAIN_WORD = 8'hA5;

endpackage

// File: rtl/cam_lvds_align_lane.sv
// One lane of bitslip training: compare the word, slip on mismatch,
// settle, and declare DONE after a run of matches or FAILED when out of slips.
module cam_lvds_align_lane
   import cam_lvds_align_pkg::*;
#(
   parameter int               DESER         = 8,
   parameter logic [DESER-1:0] TRAIN_WORD    = DEF_TRAIN_WORD,
   parameter int               MATCH_COUNT   = 16,
   parameter int               MAX_SLIPS     = 16,
   parameter int               SETTLE_CYCLES = 4
) (
   input  logic             c,
   input  logic             rst,
   input  logic             clr,
   input  logic             go,
   input  logic [DESER-1:0] word,
   output logic             bitslip,
   output logic             done,
   output logic             failed,
   output logic             active
);

   localparam int MW = (MATCH_COUNT > 1) ? $clog2(MATCH_COUNT) : 1;
   localparam int SW = $clog2(MAX_SLIPS + 1);
   localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   lane_state_t   state, state_n;
   logic [MW-1:0] match_cnt, match_n;
   logic [SW-1:0] slip_cnt, slip_n;
   logic [TW-1:0] settle_cnt, settle_n;

   always_ff @(posedge c) begin
      if (rst) begin
         state      <= L_IDLE;
         match_cnt  <= '0;
         slip_cnt   <= '0;
         settle_cnt <= '0;
         bitslip    <= 1'b0;
      end else begin
         state      <= state_n;
         match_cnt  <= match_n;
         slip_cnt   <= slip_n;
         settle_cnt <= settle_n;
         // the pulse is suppressed on the clearing edge so it never leaks out of training
         bitslip    <= (state == L_SLIP) && !clr;
      end
   end

   always_comb begin
      state_n  = state;
      match_n  = match_cnt;
      slip_n   = slip_cnt;
      settle_n = settle_cnt;
      if (clr) begin
         state_n  = L_IDLE;
         match_n  = '0;
         slip_n   = '0;
         settle_n = '0;
      end else begin
         unique case (state)
            L_IDLE: begin
               if (go) begin
                  state_n = L_CHECK;
                  match_n = '0;
                  slip_n  = '0;
               end
            end
            L_CHECK: begin
               if (word == TRAIN_WORD) begin
                  if (match_cnt == MW'(MATCH_COUNT - 1))
                     state_n = L_DONE;
                  else
                     match_n = match_cnt + MW'(1);
               end else begin
                  match_n = '0;
                  state_n = (slip_cnt == SW'(MAX_SLIPS)) ? L_FAILED : L_SLIP;
               end
            end
            L_SLIP: begin
               slip_n   = slip_cnt + SW'(1);
               settle_n = '0;
               state_n  = L_SETTLE;
            end
            L_SETTLE: begin
               if (settle_cnt == TW'(SETTLE_CYCLES - 1))
                  state_n = L_CHECK;
               else
                  settle_n = settle_cnt + TW'(1);
            end
            L_DONE:   ;
            L_FAILED: ;
            default:  state_n = L_IDLE;
         endcase
      end
   end

   assign done   = (state == L_DONE);
   assign failed = (state == L_FAILED);
   assign active = (state == L_CHECK) || (state == L_SLIP) ||
                   (state == L_SETTLE);

endmodule

// File: rtl/cam_lvds_align.sv
// Bitslip training controller: waits for a stable receiver PLL lock, then
// trains every lane in parallel and reports per-lane and overall alignment.
module cam_lvds_align
   import cam_lvds_align_pkg::*;
#(
   parameter int               NUM_CH        = 5,
   parameter int               DESER         = 8,
   parameter logic [DESER-1:0] TRAIN_WORD    = DEF_TRAIN_WORD,
   parameter int               MATCH_COUNT   = 16,
   parameter int               MAX_SLIPS     = 16,
   parameter int               SETTLE_CYCLES = 4,
   parameter int               LOCK_WAIT     = 256
) (
   input  logic                    c,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    pll_locked,
   input  logic [NUM_CH*DESER-1:0] rxd,
   output logic [NUM_CH-1:0]       bitslip,
   output logic [NUM_CH-1:0]       ch_aligned,
   output logic                    aligned,
   output logic                    fail,
   output logic                    busy
);

   localparam int LCW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

   top_state_t     state, state_n;
   logic [LCW-1:0] lock_cnt, lock_cnt_n;
   logic           lock_m, lock_s;
   logic           lane_go, lane_clr;
   logic [NUM_CH-1:0] lane_done, lane_failed, lane_active;
   logic           all_done;

   assign all_done = &lane_done;

   always_ff @(posedge c) begin
      if (rst) begin
         lock_m     <= 1'b0;
         lock_s     <= 1'b0;
         state      <= T_IDLE;
         lock_cnt   <= '0;
         ch_aligned <= '0;
         aligned    <= 1'b0;
         fail       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         lock_m     <= pll_locked;
         lock_s     <= lock_m;
         state      <= state_n;
         lock_cnt   <= lock_cnt_n;
         ch_aligned <= lane_clr ? '0 : lane_done;
         aligned    <= (state_n == T_DONE) && all_done;
         fail       <= (state_n == T_DONE) && !all_done && |lane_failed;
         busy       <= (state_n == T_WAIT_LOCK) || (state_n == T_TRAIN);
      end
   end

   always_comb begin
      state_n    = state;
      lock_cnt_n = '0;
      lane_go    = 1'b0;
      lane_clr   = 1'b0;
      // restart has priority over lock loss, which has priority over progress
      if (start) begin
         state_n  = T_WAIT_LOCK;
         lane_clr = 1'b1;
      end else if (state != T_IDLE && !lock_s) begin
         state_n  = T_WAIT_LOCK;
         lane_clr = 1'b1;
      end else begin
         unique case (state)
            T_IDLE: ;
            T_WAIT_LOCK: begin
               if (lock_cnt == LCW'(LOCK_WAIT - 1)) begin
                  state_n = T_TRAIN;
                  lane_go = 1'b1;
               end else begin
                  lock_cnt_n = lock_cnt + LCW'(1);
               end
            end
            T_TRAIN: begin
               if (all_done)
                  state_n = T_DONE;
               else if (|lane_failed && !(|lane_active))
                  state_n = T_DONE;
            end
            T_DONE: ;
            default: state_n = T_IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      cam_lvds_align_lane #(
         .DESER        (DESER),
         .TRAIN_WORD   (TRAIN_WORD),
         .MATCH_COUNT  (MATCH_COUNT),
         .MAX_SLIPS    (MAX_SLIPS),
         .SETTLE_CYCLES(SETTLE_CYCLES)
      ) u_lane (
         .c      (c),
         .rst    (rst),
         .clr    (lane_clr),
         .go     (lane_go),
         .word   (rxd[k*DESER +: DESER]),
         .bitslip(bitslip[k]),
         .done   (lane_done[k]),
         .failed (lane_failed[k]),
         .active (lane_active[k])
      );
   end

endmodule

// File: tb/tb_cam_lvds_align.sv
// Bench for cam_lvds_align: a lane model rotates each word on bitslip and a
// scoreboard checks the outcome of every training run when busy falls.
module tb_cam_lvds_align;

   localparam int NCH = 5;

   typedef struct packed {
      logic                al;
      logic                fl;
      logic [NCH-1:0]      ch;
      logic [NCH-1:0][4:0] sl;
   } exp_t;

   logic                c = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                pll_locked = 1'b0;
   logic [NCH*8-1:0]    rxd;
   logic [NCH-1:0]      bitslip, ch_aligned;
   logic                aligned, fail, busy;

   logic [7:0]          lane_w [NCH];
   logic [NCH-1:0]      p1 = '0, p2 = '0;
   logic [NCH-1:0][4:0] mon_cnt = '0;
   logic                busy_q = 1'b0;
   exp_t                sb_q [$];
   exp_t                e;
   int                  errs = 0;
   int                  checks = 0;

   cam_lvds_align dut (
      .c         (c),
      .rst       (rst),
      .start     (start),
      .pll_locked(pll_locked),
      .rxd       (rxd),
      .bitslip   (bitslip),
      .ch_aligned(ch_aligned),
      .aligned   (aligned),
      .fail      (fail),
      .busy      (busy)
   );

   always #5 c = ~c;

   always_comb begin
      rxd = '0;
      for (int k = 0; k < NCH; k++) rxd[k*8 +: 8] = lane_w[k];
   end

   function automatic logic [7:0] rotr(input logic [7:0] w, input int n);
      logic [7:0] r;
      r = w;
      for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
      return r;
   endfunction

   function automatic exp_t mk(input logic al, input logic fl,
                               input logic [NCH-1:0] ch,
                               input int c0, input int c1, input int c2,
                               input int c3, input int c4);
      exp_t r;
      r.al = al;
      r.fl = fl;
      r.ch = ch;
      r.sl = {5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_offs(input int o0, input int o1, input int o2,
                           input int o3, input int o4);
      lane_w[0] = rotr(8'hA5, o0);
      lane_w[1] = rotr(8'hA5, o1);
      lane_w[2] = rotr(8'hA5, o2);
      lane_w[3] = rotr(8'hA5, o3);
      lane_w[4] = rotr(8'hA5, o4);
   endtask

   // returns one tick after the edge that samples start (E0)
   task automatic pulse_start(input logic push, input exp_t x);
      @(posedge c);
      #1 start = 1'b1;
      if (push) sb_q.push_back(x);
      @(posedge c);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      @(negedge c);
      while (busy && n < 2000) begin
         @(negedge c);
         n++;
      end
      chk({nm, "_done"}, 32'(busy), 32'd0);
   endtask

   // lane model: a slip seen on one negedge rotates the word two cycles later
   always @(negedge c) begin
      for (int k = 0; k < NCH; k++)
         if (p2[k]) lane_w[k] = {lane_w[k][6:0], lane_w[k][7]};
      p2 = p1;
      p1 = bitslip;
   end

   always @(negedge c) begin
      if (start) mon_cnt = '0;
      for (int k = 0; k < NCH; k++)
         if (bitslip[k]) mon_cnt[k] = mon_cnt[k] + 5'd1;
      if (busy_q && !busy && !rst) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_aligned", 32'(aligned), 32'(e.al));
            chk("sb_fail", 32'(fail), 32'(e.fl));
            chk("sb_ch_aligned", 32'(ch_aligned), 32'(e.ch));
            chk("sb_slip_counts", 32'(mon_cnt), 32'(e.sl));
         end
      end
      busy_q = busy;
   end

   initial begin
      int first_bs, first_ch;
      logic [NCH-1:0] bs_or;

      set_offs(0, 3, 7, 1, 5);
      pll_locked = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge c);
      @(negedge c);
      chk("in_reset", 32'({bitslip, ch_aligned, aligned, fail, busy}), 32'd0);
      @(posedge c);
      #1 rst = 1'b0;
      @(negedge c);
      chk("after_reset", 32'({bitslip, ch_aligned, aligned, fail, busy}), 32'd0);
      repeat (5) @(posedge c);

      // 1: offsets {0,3,7,1,5}, plus first-slip and ch_aligned latency
      pulse_start(1'b1, mk(1'b1, 1'b0, 5'b11111, 0, 3, 7, 1, 5));
      first_bs = 0;
      first_ch = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge c);
         if (first_bs == 0 && |bitslip) first_bs = i;
         if (first_ch == 0 && ch_aligned[0]) first_ch = i;
      end
      chk("first_slip_cycle", 32'(first_bs), 32'd259);
      chk("ch0_aligned_cycle", 32'(first_ch), 32'd274);
      wait_idle("t1");

      // 2: lane 2 stuck at zero exhausts its slips
      set_offs(0, 3, 0, 1, 5);
      lane_w[2] = 8'h00;
      pulse_start(1'b1, mk(1'b0, 1'b1, 5'b11011, 0, 3, 16, 1, 5));
      wait_idle("t2");

      // 3: lock loss mid-training, then relock
      set_offs(0, 3, 7, 1, 5);
      pulse_start(1'b1, mk(1'b1, 1'b0, 5'b11111, 0, 3, 7, 1, 5));
      repeat (290) @(negedge c);
      chk("pre_drop_ch0", 32'(ch_aligned[0]), 32'd1);
      pll_locked = 1'b0;
      repeat (3) @(posedge c);
      @(negedge c);
      chk("drop_bitslip", 32'(bitslip), 32'd0);
      chk("drop_ch_aligned", 32'(ch_aligned), 32'd0);
      chk("drop_busy", 32'(busy), 32'd1);
      repeat (10) @(negedge c);
      pll_locked = 1'b1;
      bs_or = '0;
      repeat (256) begin
         @(negedge c);
         bs_or = bs_or | bitslip;
      end
      chk("relock_quiet", 32'(bs_or), 32'd0);
      wait_idle("t3");

      // 4: lane 0 loses phase after exactly 15 matches
      set_offs(0, 3, 7, 1, 5);
      pulse_start(1'b1, mk(1'b1, 1'b0, 5'b11111, 1, 3, 7, 1, 5));
      repeat (271) @(posedge c);
      #1 lane_w[0] = rotr(8'hA5, 1);
      wait_idle("t4");

      // 5: reset while lanes are settling, then a clean retrain
      set_offs(0, 3, 7, 1, 5);
      pulse_start(1'b0, mk(1'b0, 1'b0, 5'b00000, 0, 0, 0, 0, 0));
      repeat (259) @(posedge c);
      #1 rst = 1'b1;
      @(posedge c);
      @(negedge c);
      chk("rst_mid_train", 32'({bitslip, ch_aligned, aligned, fail, busy}), 32'd0);
      @(posedge c);
      #1 rst = 1'b0;
      repeat (10) @(posedge c);
      set_offs(0, 3, 7, 1, 5);
      pulse_start(1'b1, mk(1'b1, 1'b0, 5'b11111, 0, 3, 7, 1, 5));
      wait_idle("t5");
      chk("t5_aligned_hold", 32'(aligned), 32'd1);

      // 6: restart from DONE
      set_offs(0, 3, 7, 1, 5);
      pulse_start(1'b1, mk(1'b1, 1'b0, 5'b11111, 0, 3, 7, 1, 5));
      @(negedge c);
      chk("restart_aligned", 32'(aligned), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      wait_idle("t6");

      repeat (2) @(negedge c);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
